// File: rtl/fp_pkg.sv
// Shared constants and types for the single-precision multiply rounding path.
// Contents:
//   FP32 field widths, canonical quiet NaN, exponent bias/limit,
//   out_flags bit indices, the stage-1 bundle struct and a pack helper.
package fp_pkg;

  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned EXP8_W   = 8;
  localparam int unsigned PROD_W   = 48;
  localparam int unsigned FP32_W   = 32;
  localparam int unsigned FLAGS_W  = 4;

  // Internal exponent width carried between stages; wide enough for any
  // supported EXP_W plus the normalise and round-carry increments.
  localparam int unsigned S1_EXP_W = 16;

  localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;
  localparam int                EXP_BIAS  = 127;
  localparam int                EXP_MAX   = 255;

  // out_flags = {invalid, overflow, underflow, inexact}
  localparam int unsigned FLAG_INEXACT   = 0;
  localparam int unsigned FLAG_UNDERFLOW = 1;
  localparam int unsigned FLAG_OVERFLOW  = 2;
  localparam int unsigned FLAG_INVALID   = 3;

  // Normalised operand bundle held between stage 1 and stage 2.
  typedef struct packed {
    logic                       sign;
    logic signed [S1_EXP_W-1:0] exp;
    logic [FRAC_W-1:0]          man;
    logic                       g;
    logic                       s;
    logic                       nan;
    logic                       inf;
    logic                       zero;
  } s1_bundle_t;

  // Assemble an IEEE754 single from its fields.
  function automatic logic [FP32_W-1:0] fp32_pack(input logic              sign,
                                                  input logic [EXP8_W-1:0] exp8,
                                                  input logic [FRAC_W-1:0] frac);
    return {sign, exp8, frac};
  endfunction

endpackage

// File: rtl/fp_rne_round.sv
// Combinational mantissa rounder shared by the FP multiply/add round stages.
// Ports:
//   ROUND_EN     1: round-to-nearest-even, 0: truncate
//   man_i        23-bit fraction (hidden bit implied)
//   g_i, s_i     guard and sticky bits below the fraction LSB
//   exp_i        signed biased exponent before rounding
//   man_c_o      rounded fraction
//   exp_c_o      exponent after a possible round carry
//   inexact_c_o  any discarded bits were non-zero
module fp_rne_round
  import fp_pkg::*;
#(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic                       g_i,
  input  logic                       s_i,
  input  logic [FRAC_W-1:0]          man_i,
  input  logic signed [S1_EXP_W-1:0] exp_i,
  output logic [FRAC_W-1:0]          man_c_o,
  output logic signed [S1_EXP_W-1:0] exp_c_o,
  output logic                       inexact_c_o
);

  localparam int unsigned SUM_W = FRAC_W + 1;

  logic             up;
  logic [SUM_W-1:0] sum;

  // Round up on guard when sticky is set or the LSB is odd (ties to even).
  always_comb begin
    up          = 1'b0;
    sum         = '0;
    man_c_o     = man_i;
    exp_c_o     = exp_i;
    inexact_c_o = g_i | s_i;

    if (ROUND_EN) begin
      up = g_i & (s_i | man_i[0]);
    end

    sum = {1'b0, man_i} + SUM_W'(up);

    // Fraction overflow: 1.111..1 + ulp = 10.000..0, renormalise by one.
    if (sum[SUM_W-1]) begin
      man_c_o = '0;
      exp_c_o = exp_i + S1_EXP_W'(1);
    end else begin
      man_c_o = sum[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/fp_mul_round_stage.sv
// Two-stage normalise / round / exception stage for the FP32 multiplier.
// Stage 1 registers the normalised bundle, stage 2 rounds, saturates,
// applies special-case overrides and registers the packed result.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  upstream handshake (in_ready is combinational from out_ready)
//   in_sign         product sign
//   in_exp          signed biased exponent sum ea+eb-127, pre-normalise
//   in_prod         48-bit mantissa product, 46 fraction bits
//   in_nan/inf/zero operand class flags
//   out_valid/ready downstream handshake
//   out_result      packed IEEE754 result
//   out_flags       {invalid, overflow, underflow, inexact}
module fp_mul_round_stage
  import fp_pkg::*;
#(
  parameter bit          ROUND_EN = 1'b1,
  parameter int unsigned EXP_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [PROD_W-1:0]       in_prod,
  input  logic                    in_nan,
  input  logic                    in_inf,
  input  logic                    in_zero,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FP32_W-1:0]       out_result,
  output logic [FLAGS_W-1:0]      out_flags
);

  localparam int unsigned EW1 = EXP_W + 1;

  localparam logic signed [S1_EXP_W-1:0] E_MAX  = S1_EXP_W'(EXP_MAX);
  localparam logic signed [S1_EXP_W-1:0] E_ZERO = S1_EXP_W'(0);

  // Pipeline registers
  logic                  s1_valid_q;
  s1_bundle_t            s1_q;
  logic                  out_valid_q;
  logic [FP32_W-1:0]     out_result_q;
  logic [FLAGS_W-1:0]    out_flags_q;

  // Next-state values
  s1_bundle_t            s1_d;
  logic [FP32_W-1:0]     res_d;
  logic [FLAGS_W-1:0]    flags_d;

  // Handshake
  logic                  s2_advance_c;
  logic                  in_ready_c;

  // Normalise intermediates
  logic signed [EW1-1:0] exp_ext;
  logic signed [EW1-1:0] exp_norm;

  // Rounder outputs
  logic [FRAC_W-1:0]          rnd_man;
  logic signed [S1_EXP_W-1:0] rnd_exp;
  logic                       rnd_inexact;

  // Stage 2 drains whenever the output slot is empty or being consumed;
  // stage 1 can then always hand its bundle on, so it accepts whenever
  // it is empty or stage 2 advances.
  assign s2_advance_c = ~out_valid_q | out_ready;
  assign in_ready_c   = ~s1_valid_q | s2_advance_c;

  // Stage 1: align the product so the leading one is the hidden bit.
  always_comb begin
    s1_d      = '0;
    exp_ext   = EW1'(in_exp);
    exp_norm  = exp_ext;

    s1_d.sign = in_sign;
    s1_d.nan  = in_nan;
    s1_d.inf  = in_inf;
    s1_d.zero = in_zero;

    if (in_prod[PROD_W-1]) begin
      // Product in [2,4): shift right one place.
      s1_d.man = in_prod[46:24];
      s1_d.g   = in_prod[23];
      s1_d.s   = |in_prod[22:0];
      exp_norm = exp_ext + EW1'(1);
    end else begin
      s1_d.man = in_prod[45:23];
      s1_d.g   = in_prod[22];
      s1_d.s   = |in_prod[21:0];
      exp_norm = exp_ext;
    end

    s1_d.exp = S1_EXP_W'(exp_norm);
  end

  fp_rne_round #(
    .ROUND_EN (ROUND_EN)
  ) u_round (
    .g_i         (s1_q.g),
    .s_i         (s1_q.s),
    .man_i       (s1_q.man),
    .exp_i       (s1_q.exp),
    .man_c_o     (rnd_man),
    .exp_c_o     (rnd_exp),
    .inexact_c_o (rnd_inexact)
  );

  // Stage 2: specials first, then saturation of the rounded exponent.
  always_comb begin
    res_d   = '0;
    flags_d = '0;

    if (s1_q.nan | (s1_q.inf & s1_q.zero)) begin
      res_d                 = FP32_QNAN;
      flags_d[FLAG_INVALID] = 1'b1;
    end else if (s1_q.inf) begin
      res_d = fp32_pack(s1_q.sign, '1, '0);
    end else if (s1_q.zero) begin
      res_d = fp32_pack(s1_q.sign, '0, '0);
    end else if (rnd_exp >= E_MAX) begin
      res_d                  = fp32_pack(s1_q.sign, '1, '0);
      flags_d[FLAG_OVERFLOW] = 1'b1;
      flags_d[FLAG_INEXACT]  = 1'b1;
    end else if (rnd_exp <= E_ZERO) begin
      // No subnormal support: flush to signed zero.
      res_d                   = fp32_pack(s1_q.sign, '0, '0);
      flags_d[FLAG_UNDERFLOW] = 1'b1;
      flags_d[FLAG_INEXACT]   = 1'b1;
    end else begin
      res_d                 = fp32_pack(s1_q.sign, rnd_exp[EXP8_W-1:0], rnd_man);
      flags_d[FLAG_INEXACT] = rnd_inexact;
    end
  end

  // Pipeline state; results only load on a real hand-off so they hold
  // stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      if (s2_advance_c) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          out_result_q <= res_d;
          out_flags_q  <= flags_d;
        end
      end
      if (in_ready_c) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_q <= s1_d;
        end
      end
    end
  end

  assign in_ready   = in_ready_c;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp_mul_round_stage.sv
// Directed bench for fp_mul_round_stage: a vector table streamed back to back
// through a rounding and a truncating instance, then backpressure and
// mid-stream reset sequences.
module tb_fp_mul_round_stage;
  import fp_pkg::*;

  localparam int unsigned EXP_W = 10;
  localparam int unsigned NV    = 18;

  localparam logic [3:0] F_NONE  = 4'b0000;
  localparam logic [3:0] F_NX    = 4'b0001;
  localparam logic [3:0] F_UF_NX = 4'b0011;
  localparam logic [3:0] F_OF_NX = 4'b0101;
  localparam logic [3:0] F_NV    = 4'b1000;

  typedef struct {
    logic        sign;
    int          e;
    logic [47:0] prod;
    logic        nan;
    logic        inf;
    logic        zero;
    logic [31:0] res;
    logic [3:0]  flags;
    logic [31:0] res_t;
    logic [3:0]  flags_t;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_ready_t;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [47:0]       in_prod;
  logic              in_nan;
  logic              in_inf;
  logic              in_zero;
  logic              out_valid;
  logic              out_valid_t;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [31:0]       out_result_t;
  logic [3:0]        out_flags;
  logic [3:0]        out_flags_t;

  int n_pass  = 0;
  int n_total = 0;

  vec_t vecs[NV];

  always #5 clk = ~clk;

  fp_mul_round_stage #(.ROUND_EN(1'b1), .EXP_W(EXP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_prod    (in_prod),
    .in_nan     (in_nan),
    .in_inf     (in_inf),
    .in_zero    (in_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  fp_mul_round_stage #(.ROUND_EN(1'b0), .EXP_W(EXP_W)) dut_t (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready_t),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_prod    (in_prod),
    .in_nan     (in_nan),
    .in_inf     (in_inf),
    .in_zero    (in_zero),
    .out_valid  (out_valid_t),
    .out_ready  (out_ready),
    .out_result (out_result_t),
    .out_flags  (out_flags_t)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic drive(input vec_t v, input logic valid);
    in_valid = valid;
    in_sign  = v.sign;
    in_exp   = EXP_W'(v.e);
    in_prod  = v.prod;
    in_nan   = v.nan;
    in_inf   = v.inf;
    in_zero  = v.zero;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          sign e          prod                nan  inf  zero  res           flags    res_t         flags_t
    vecs[0]  = '{1'b0, EXP_BIAS,   48'h9000_0000_0000, 1'b0,1'b0,1'b0, 32'h4010_0000, F_NONE,  32'h4010_0000, F_NONE};
    vecs[1]  = '{1'b0, EXP_BIAS,   48'h4000_0040_0000, 1'b0,1'b0,1'b0, 32'h3F80_0000, F_NX,    32'h3F80_0000, F_NX};
    vecs[2]  = '{1'b0, EXP_BIAS,   48'h4000_00C0_0000, 1'b0,1'b0,1'b0, 32'h3F80_0002, F_NX,    32'h3F80_0001, F_NX};
    vecs[3]  = '{1'b0, EXP_BIAS,   48'hFFFF_FF80_0000, 1'b0,1'b0,1'b0, 32'h4080_0000, F_NX,    32'h407F_FFFF, F_NX};
    vecs[4]  = '{1'b0, EXP_BIAS,   48'h4000_0060_0000, 1'b0,1'b0,1'b0, 32'h3F80_0001, F_NX,    32'h3F80_0000, F_NX};
    vecs[5]  = '{1'b0, EXP_BIAS,   48'h4000_0020_0000, 1'b0,1'b0,1'b0, 32'h3F80_0000, F_NX,    32'h3F80_0000, F_NX};
    vecs[6]  = '{1'b0, 254,        48'h8000_0000_0000, 1'b0,1'b0,1'b0, 32'h7F80_0000, F_OF_NX, 32'h7F80_0000, F_OF_NX};
    vecs[7]  = '{1'b1, 0,          48'h4000_0000_0000, 1'b0,1'b0,1'b0, 32'h8000_0000, F_UF_NX, 32'h8000_0000, F_UF_NX};
    vecs[8]  = '{1'b0, 253,        48'hFFFF_FF80_0000, 1'b0,1'b0,1'b0, 32'h7F80_0000, F_OF_NX, 32'h7F7F_FFFF, F_NX};
    vecs[9]  = '{1'b0, 253,        48'h8000_0000_0000, 1'b0,1'b0,1'b0, 32'h7F00_0000, F_NONE,  32'h7F00_0000, F_NONE};
    vecs[10] = '{1'b0, 1,          48'h4000_0000_0000, 1'b0,1'b0,1'b0, 32'h0080_0000, F_NONE,  32'h0080_0000, F_NONE};
    vecs[11] = '{1'b0, -5,         48'h8000_0000_0000, 1'b0,1'b0,1'b0, 32'h0000_0000, F_UF_NX, 32'h0000_0000, F_UF_NX};
    vecs[12] = '{1'b1, 381,        48'h4000_0000_0000, 1'b0,1'b0,1'b0, 32'hFF80_0000, F_OF_NX, 32'hFF80_0000, F_OF_NX};
    vecs[13] = '{1'b0, EXP_BIAS,   48'h9000_0000_0000, 1'b0,1'b1,1'b1, 32'h7FC0_0000, F_NV,    32'h7FC0_0000, F_NV};
    vecs[14] = '{1'b1, EXP_BIAS,   48'h9000_0000_0000, 1'b0,1'b1,1'b0, 32'hFF80_0000, F_NONE,  32'hFF80_0000, F_NONE};
    vecs[15] = '{1'b1, EXP_BIAS,   48'h9000_0000_0000, 1'b1,1'b1,1'b0, 32'h7FC0_0000, F_NV,    32'h7FC0_0000, F_NV};
    vecs[16] = '{1'b1, EXP_BIAS,   48'h9000_0000_0000, 1'b0,1'b0,1'b1, 32'h8000_0000, F_NONE,  32'h8000_0000, F_NONE};
    // Exponent 0 before rounding, lifted to the smallest normal by the carry.
    vecs[17] = '{1'b0, -1,         48'hFFFF_FF80_0000, 1'b0,1'b0,1'b0, 32'h0080_0000, F_NX,    32'h0000_0000, F_UF_NX};

    // Reset state
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(vecs[0], 1'b0);
    #12;
    check("rst_out_valid",  32'(out_valid),  32'h0);
    check("rst_out_result", out_result,      32'h0);
    check("rst_out_flags",  32'(out_flags),  32'h0);
    check("rst_in_ready",   32'(in_ready),   32'h1);
    check("rst_in_ready_t", 32'(in_ready_t), 32'h1);
    rst = 1'b0;
    tick();

    // Table stream, one bundle per cycle, results two edges after issue
    for (int i = 0; i <= int'(NV); i++) begin
      if (i < int'(NV)) begin
        drive(vecs[i], 1'b1);
        check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'h1);
      end else begin
        drive(vecs[0], 1'b0);
      end
      tick();
      if (i == 0) begin
        check("first_latency_out_valid", 32'(out_valid), 32'h0);
      end else begin
        check($sformatf("vec%0d_valid", i-1),   32'(out_valid),   32'h1);
        check($sformatf("vec%0d_result", i-1),  out_result,       vecs[i-1].res);
        check($sformatf("vec%0d_flags", i-1),   32'(out_flags),   32'(vecs[i-1].flags));
        check($sformatf("vec%0d_trunc_result", i-1), out_result_t, vecs[i-1].res_t);
        check($sformatf("vec%0d_trunc_flags", i-1),  32'(out_flags_t), 32'(vecs[i-1].flags_t));
      end
    end
    tick();
    check("drain_out_valid", 32'(out_valid), 32'h0);

    // Backpressure: two bundles fill the pipe, the third waits
    out_ready = 1'b0;
    drive(vecs[0], 1'b1);
    check("bp_in_ready_a", 32'(in_ready), 32'h1);
    tick();
    drive(vecs[1], 1'b1);
    check("bp_in_ready_b", 32'(in_ready), 32'h1);
    tick();
    drive(vecs[2], 1'b1);
    check("bp_in_ready_full", 32'(in_ready), 32'h0);
    check("bp_out_valid", 32'(out_valid), 32'h1);
    check("bp_out_result", out_result, vecs[0].res);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bp_hold%0d_valid", k),  32'(out_valid), 32'h1);
      check($sformatf("bp_hold%0d_result", k), out_result, vecs[0].res);
      check($sformatf("bp_hold%0d_flags", k),  32'(out_flags), 32'(vecs[0].flags));
      check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'h1);
    check("bp_release_a", out_result, vecs[0].res);
    tick();
    drive(vecs[0], 1'b0);
    check("bp_b_valid",  32'(out_valid), 32'h1);
    check("bp_b_result", out_result, vecs[1].res);
    tick();
    check("bp_c_valid",  32'(out_valid), 32'h1);
    check("bp_c_result", out_result, vecs[2].res);
    check("bp_c_flags",  32'(out_flags), 32'(vecs[2].flags));
    tick();
    check("bp_empty", 32'(out_valid), 32'h0);

    // Reset mid-stream drops everything in flight
    drive(vecs[3], 1'b1);
    tick();
    drive(vecs[4], 1'b1);
    tick();
    check("mid_pre_valid", 32'(out_valid), 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid",  32'(out_valid), 32'h0);
    check("mid_rst_out_result", out_result, 32'h0);
    check("mid_rst_out_flags",  32'(out_flags), 32'h0);
    check("mid_rst_in_ready",   32'(in_ready), 32'h1);
    drive(vecs[0], 1'b0);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mid_post%0d_valid", k), 32'(out_valid), 32'h0);
    end
    drive(vecs[2], 1'b1);
    tick();
    drive(vecs[0], 1'b0);
    tick();
    check("mid_fresh_valid",  32'(out_valid), 32'h1);
    check("mid_fresh_result", out_result, 32'h3F80_0002);
    check("mid_fresh_trunc",  out_result_t, 32'h3F80_0001);
    tick();
    check("mid_fresh_drain", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
